// File: rtl/shift_rows_stream_if.sv
// Valid/ready stream carrying one AES state word plus its ShiftRows mode tag.
//   valid : producer has a word
//   ready : consumer can take it
//   inv   : 0 = ShiftRows, 1 = InvShiftRows
//   data  : state word, column-major, W = 32*NB bits
// master = producer side, slave = consumer side.
interface shift_rows_stream_if #(
    parameter int W = 128
);
    logic         valid;
    logic         ready;
    logic         inv;
    logic [W-1:0] data;

    modport master (output valid, output inv, output data, input  ready);
    modport slave  (input  valid, input  inv, input  data, output ready);
endinterface

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows / InvShiftRows stage with a small output FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of the buffer (wins over push and pop)
//   in_s       : slave stream; word is permuted combinationally and written on push
//   out_s      : master stream; presents the buffer head
//   count      : buffer occupancy, 0..DEPTH
// Byte (r,c) of a state lives at bits [W-1-8*(4c+r) -: 8].
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    shift_rows_stream_if.slave         in_s,
    shift_rows_stream_if.master        out_s,
    output logic [1:0]                 count
);
    localparam int         W       = 32 * NB;
    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
        if (!(DEPTH == 1 || DEPTH == 2)) begin : g_bad_depth
            $error("shift_rows_stream: DEPTH must be 1 or 2");
        end
    endgenerate

    // Rijndael row offsets: 256-bit blocks shift rows 2 and 3 one further.
    function automatic int row_shift(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Pure wiring: each output byte picks its source column at elaboration.
    logic [W-1:0] fwd_w, inv_w, perm_w;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int S  = row_shift(r);
            localparam int CF = (c + S) % NB;
            localparam int CI = (c - S + NB) % NB;
            assign fwd_w[W-1-8*(4*c+r) -: 8] = in_s.data[W-1-8*(4*CF+r) -: 8];
            assign inv_w[W-1-8*(4*c+r) -: 8] = in_s.data[W-1-8*(4*CI+r) -: 8];
        end
    end

    assign perm_w = in_s.inv ? inv_w : fwd_w;

    logic [W-1:0]    mem     [DEPTH];
    logic            mem_inv [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            rdy_en;   // keeps in_ready low until the first edge out of reset
    logic            push, pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : PW'(int'(p) + 1);
    endfunction

    // in_ready depends only on registered state, so no ready/valid loop forms.
    assign in_s.ready  = rdy_en && (count < DEPTH_C);
    assign out_s.valid = (count != 2'd0);
    assign out_s.data  = mem[rd_ptr];
    assign out_s.inv   = mem_inv[rd_ptr];

    assign push = in_s.valid && in_s.ready;
    assign pop  = out_s.valid && out_s.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_en <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]     <= '0;
                mem_inv[i] <= 1'b0;
            end
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i]     <= '0;
                    mem_inv[i] <= 1'b0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr]     <= perm_w;
                    mem_inv[wr_ptr] <= in_s.inv;
                    wr_ptr          <= ptr_next(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench for shift_rows_stream: NB=4/DEPTH=2 and NB=8/DEPTH=2 instances.
module tb_shift_rows_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush4, flush8;
    logic [1:0] count4, count8;
    int         nchk = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    shift_rows_stream_if #(.W(128)) i4 ();
    shift_rows_stream_if #(.W(128)) o4 ();
    shift_rows_stream_if #(.W(256)) i8 ();
    shift_rows_stream_if #(.W(256)) o8 ();

    shift_rows_stream #(.NB(4), .DEPTH(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4), .in_s(i4.slave), .out_s(o4.master), .count(count4)
    );
    shift_rows_stream #(.NB(8), .DEPTH(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .in_s(i8.slave), .out_s(o8.master), .count(count8)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: state in the low 32*nb bits, byte (r,c) at [32nb-1-8(4c+r) -: 8].
    function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input bit inv);
        logic [255:0] o;
        int w, s, src;
        o = '0;
        w = 32 * nb;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                s   = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - s + nb) % nb : (c + s) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] WB       = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] WC       = 128'h0f0e0d0c0b0a09080706050403020100;

    logic [255:0] ramp;
    logic [128:0] q[$];
    logic [128:0] exp_e;
    logic [255:0] tmp;
    int           sent, rcv, cyc;
    bit           pushed;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush4 = 1'b0; flush8 = 1'b0;
        i4.valid = 1'b0; i4.inv = 1'b0; i4.data = '0; o4.ready = 1'b0;
        i8.valid = 1'b0; i8.inv = 1'b0; i8.data = '0; o8.ready = 1'b0;
        for (int k = 0; k < 32; k++) ramp[255-8*k -: 8] = 8'(k);

        // Reset state
        #3;
        chk("rst_in_ready", 256'(i4.ready), 256'd0);
        chk("rst_count", 256'(count4), 256'd0);
        chk("rst_out_valid", 256'(o4.valid), 256'd0);
        chk("rst_out_data", 256'(o4.data), 256'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready_low", 256'(i4.ready), 256'd0);
        tick();
        chk("rst_rel_ready_high", 256'(i4.ready), 256'd1);

        // FIPS-197 round 1 ShiftRows, then inverse on the result
        i4.valid = 1'b1; i4.data = FIPS_IN; i4.inv = 1'b0;
        tick();
        i4.valid = 1'b0;
        chk("fips_valid", 256'(o4.valid), 256'd1);
        chk("fips_fwd", 256'(o4.data), 256'(FIPS_OUT));
        chk("fips_fwd_tag", 256'(o4.inv), 256'd0);
        chk("fips_count", 256'(count4), 256'd1);
        o4.ready = 1'b1;
        tick();
        chk("fips_drained", 256'(count4), 256'd0);
        o4.ready = 1'b0;
        i4.valid = 1'b1; i4.data = FIPS_OUT; i4.inv = 1'b1;
        tick();
        i4.valid = 1'b0;
        chk("fips_inv", 256'(o4.data), 256'(FIPS_IN));
        chk("fips_inv_tag", 256'(o4.inv), 256'd1);
        o4.ready = 1'b1;
        tick();
        o4.ready = 1'b0;

        // NB=8 forward and inverse on a byte ramp
        i8.valid = 1'b1; i8.data = ramp; i8.inv = 1'b0; o8.ready = 1'b1;
        tick();
        chk("nb8_valid", 256'(o8.valid), 256'd1);
        tmp = o8.data;
        chk("nb8_r2c0", 256'(tmp[239:232]), 256'h0e);
        chk("nb8_r3c0", 256'(tmp[231:224]), 256'h13);
        chk("nb8_fwd", o8.data, ref_perm(ramp, 8, 1'b0));
        i8.inv = 1'b1;
        tick();
        i8.valid = 1'b0;
        tmp = o8.data;
        chk("nb8_inv_r1c0", 256'(tmp[247:240]), 256'h1d);
        chk("nb8_inv", o8.data, ref_perm(ramp, 8, 1'b1));
        chk("nb8_inv_tag", 256'(o8.inv), 256'd1);
        tick();
        chk("nb8_drained", 256'(count8), 256'd0);
        o8.ready = 1'b0;

        // Backpressure: A, B accepted, C held until the first pop
        i4.valid = 1'b1; i4.data = FIPS_IN; i4.inv = 1'b0;
        tick();
        i4.data = WB; i4.inv = 1'b1;
        tick();
        i4.data = WC; i4.inv = 1'b0;
        chk("bp_full_count", 256'(count4), 256'd2);
        chk("bp_full_ready", 256'(i4.ready), 256'd0);
        tick();
        chk("bp_held_count", 256'(count4), 256'd2);
        chk("bp_head_a", 256'(o4.data), ref_perm(256'(FIPS_IN), 4, 1'b0));
        o4.ready = 1'b1;
        tick();
        chk("bp_pop1_count", 256'(count4), 256'd1);
        chk("bp_pop1_ready", 256'(i4.ready), 256'd1);
        chk("bp_head_b", 256'(o4.data), ref_perm(256'(WB), 4, 1'b1));
        chk("bp_head_b_tag", 256'(o4.inv), 256'd1);
        tick();
        i4.valid = 1'b0;
        chk("bp_pushpop_count", 256'(count4), 256'd1);
        chk("bp_head_c", 256'(o4.data), ref_perm(256'(WC), 4, 1'b0));
        tick();
        chk("bp_empty", 256'(o4.valid), 256'd0);
        o4.ready = 1'b0;

        // Random out_ready stream with scoreboard
        sent = 0; rcv = 0; cyc = 0;
        i4.valid = 1'b1; i4.data = {$urandom, $urandom, $urandom, $urandom}; i4.inv = 1'($urandom);
        o4.ready = 1'($urandom_range(0, 1));
        while (rcv < 1000 && cyc < 20000) begin
            pushed = i4.valid && i4.ready;
            if (pushed) begin
                tmp = ref_perm(256'(i4.data), 4, i4.inv);
                q.push_back({i4.inv, tmp[127:0]});
                sent++;
            end
            if (o4.valid && o4.ready) begin
                if (q.size() == 0) begin
                    chk("stream_extra_word", 256'd1, 256'd0);
                end else begin
                    exp_e = q.pop_front();
                    chk("stream_word", 256'({o4.inv, o4.data}), 256'(exp_e));
                end
                rcv++;
            end
            tick();
            cyc++;
            if (pushed) begin
                i4.data  = {$urandom, $urandom, $urandom, $urandom};
                i4.inv   = 1'($urandom);
                i4.valid = (sent < 1000);
            end
            o4.ready = 1'($urandom_range(0, 1));
        end
        i4.valid = 1'b0; o4.ready = 1'b0;
        chk("stream_received", 256'(rcv), 256'd1000);
        chk("stream_leftover", 256'(q.size()), 256'd0);

        // Mid-stream reset with a full buffer
        i4.valid = 1'b1; i4.data = WB; i4.inv = 1'b0;
        tick(); tick();
        i4.valid = 1'b0;
        chk("mid_full", 256'(count4), 256'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(o4.valid), 256'd0);
        chk("mid_rst_count", 256'(count4), 256'd0);
        chk("mid_rst_data", 256'(o4.data), 256'd0);
        chk("mid_rst_ready", 256'(i4.ready), 256'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", 256'(i4.ready), 256'd1);

        // Flush colliding with a push
        i4.valid = 1'b1; i4.data = WC; i4.inv = 1'b1;
        tick();
        chk("flush_pre_count", 256'(count4), 256'd1);
        flush4 = 1'b1; i4.data = WB; i4.inv = 1'b0;
        #1;
        chk("flush_ready", 256'(i4.ready), 256'd1);
        tick();
        flush4 = 1'b0; i4.valid = 1'b0;
        chk("flush_count", 256'(count4), 256'd0);
        chk("flush_valid", 256'(o4.valid), 256'd0);
        tick();
        chk("flush_dropped", 256'(count4), 256'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
